sdp_ram_stream_reader: RTL
==========================

# sdp_ram_stream_reader

Read-side engine for `simple_dual_port_ram` port B. It accepts a (start address, length) command and drives `renb`/`raddrb` to fetch consecutive words, absorbing the RAM's fixed 1-cycle read latency. It emits the words as a valid/ready stream with backpressure and `last` marking. It sits between the RAM's read port and any downstream consumer; a separate writer fills port A.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: RAM word width.
- `ADDR_WIDTH`, default 7: RAM address width; depth is 2**ADDR_WIDTH.

Ports:
- `clk`  in  1  single clock, rising edge; also drives RAM `clkb`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_addr`  in  ADDR_WIDTH  first word address.
- `cmd_len`  in  ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH.
- `ram_renb`  out  1  to RAM `renb`.
- `ram_raddrb`  out  ADDR_WIDTH  to RAM `raddrb`.
- `ram_doutb`  in  DATA_WIDTH  from RAM `doutb`; valid in the cycle after a sampled `renb`.
- `m_valid`  out  1  stream data valid.
- `m_ready`  in  1  stream consumer ready.
- `m_data`  out  DATA_WIDTH  stream word.
- `m_last`  out  1  marks the final word of a command.
- `busy`  out  1  high while not IDLE.
- `done`  out  1  one-cycle pulse on command completion.

## Operation
- **States.**
  - IDLE: `cmd_ready`=1. On `cmd_valid && cmd_ready`, latch the address and the remaining-issue count (`cmd_len`).
    - If `cmd_len` is 0, go to DONE.
    - Otherwise go to READ.
  - READ: issue reads until the remaining-issue count is 0, then go to DRAIN.
  - DRAIN: wait until no read is in flight and the buffer is empty, then go to DONE.
  - DONE: one cycle with `done`=1, then IDLE.
- **Buffer.** 2-entry output FIFO. Track `inflight` (0..1) and `count` (0..2).
- **Issue rule.**
  - Combinational: `ram_renb` = READ && remaining≠0 && (count + inflight − pop) < 2, where pop = `m_valid && m_ready`.
  - `ram_renb` therefore depends combinationally on `m_ready`; this is intended.
- **Issued read.**
  - `ram_raddrb` = current address.
  - The address increments modulo 2**ADDR_WIDTH, so ADDR_WIDTH-bit arithmetic wraps naturally.
  - The remaining-issue count decrements.
  - `inflight` is set for one cycle, and the returned `ram_doutb` is pushed into the FIFO.
- **Outputs.**
  - `m_valid` = FIFO non-empty; `m_data` = FIFO head.
  - `m_last` = head is the final word of the command (tag bit stored per entry).
- **Stream rule.** While `m_valid && !m_ready`, `m_data` and `m_last` stay stable and `m_valid` stays high.
- **No data loss.** No word is dropped or duplicated under any `m_ready` pattern.
- **Commands while busy.** `cmd_valid` outside IDLE is ignored; `cmd_ready` is 0.
- **Reset.**
  - Values during reset: state IDLE, FIFO empty, `inflight`=0.
  - Outputs during reset: `cmd_ready`=1; `ram_renb`, `m_valid`, `m_last`, `busy`, `done`=0; `ram_raddrb`, `m_data`=0.
  - Reset mid-transfer aborts immediately; any outstanding RAM read data is discarded.

## Timing
- **Accept to first word.** Command accepted at edge E0. `ram_renb`=1 with `ram_raddrb`=`cmd_addr` during E0→E1. Data is captured at E2. `m_valid`=1 after E2: two cycles from accept to first word.
- **Throughput.** With `m_ready` held high, one word per cycle; N words occupy N consecutive `m_valid` cycles.
- **Completion.** Last beat handshake at edge Ek, then DONE (`done`=1) during Ek→Ek+1, then IDLE. `cmd_ready`=1 after Ek+1. Back-to-back command gap is 1 cycle.
- **Zero length.** `cmd_len`=0: `done` is high the cycle after acceptance; no `ram_renb`, no beats.

## Structure
- **Package `sdp_ram_pkg`:**
  - state enum {IDLE, READ, DRAIN, DONE};
  - `RD_LATENCY`=1;
  - `BUF_DEPTH`=2.
- **Sub-module `sdp_rd_skid_fifo`:** 2-entry, DATA_WIDTH+1 bits wide (data + last tag); push/pop/count; async active-low reset.
- **Top:** FSM, address/remaining counters, in-flight flag, issue logic.

## Test plan
1. **Full sweep.**
   - Stimulus: preload RAM addr k with k+1 (k=0..127, 8-bit); command addr 0, len 128, `m_ready`=1.
   - Response: 128 beats carrying 1..128; `m_last` only on the beat with 128; first `m_valid` 2 cycles after accept; `done` 1 cycle after the last beat.
2. **Wrap.**
   - Stimulus: command addr 126, len 4.
   - Response: `ram_raddrb` sequence 126, 127, 0, 1; data 127, 128, 1, 2; `m_last` on 2.
3. **Backpressure.**
   - Stimulus: `m_ready` toggles every cycle, then is held low 10 cycles mid-stream (len 16 from addr 10).
   - Response: data 11..26 exactly once, in order; `m_data` stable while stalled; `ram_renb`=0 whenever count+inflight=2 and no pop.
4. **Zero length.**
   - Stimulus: command len 0.
   - Response: no `ram_renb`, no `m_valid`; `done` pulses on the next cycle; `cmd_ready` returns.
5. **Busy / back-to-back.**
   - Stimulus: `cmd_valid` held during a len-8 transfer.
   - Response: not accepted until IDLE; second command accepted the cycle after `done`; its first `m_valid` arrives 2 cycles later.
6. **Reset mid-transfer.**
   - Stimulus: assert `rst_n`=0 after 5 of 20 beats.
   - Response: `m_valid`, `ram_renb`, `busy`=0 immediately and `cmd_ready`=1; a new command (addr 0, len 2) returns 1, 2.

Source files
------------

// File: rtl/sdp_ram_pkg.sv
// Shared types and constants for the simple-dual-port RAM read streamer.
package sdp_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } rd_state_e;

  localparam int RD_LATENCY = 1;
  localparam int BUF_DEPTH  = 2;

endpackage

// File: rtl/sdp_rd_skid_fifo.sv
// Two-entry FIFO that absorbs RAM read returns while the stream consumer stalls.
module sdp_rd_skid_fifo
  import sdp_ram_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [WIDTH-1:0] mem_d [BUF_DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // Storage is cleared too so the stream data output reads zero in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/sdp_ram_stream_reader.sv
// Reads a run of consecutive RAM words from port B and emits them as a
// valid/ready stream with last marking, hiding the one-cycle read latency.
module sdp_ram_stream_reader
  import sdp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic                  ram_renb,
  output logic [ADDR_WIDTH-1:0] ram_raddrb,
  input  logic [DATA_WIDTH-1:0] ram_doutb,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;

  logic [1:0]            fifo_count;
  logic [DATA_WIDTH:0]   fifo_head;
  logic                  pop;
  logic                  issue;
  logic                  last_issue;
  logic [2:0]            occ_after;

  assign m_valid = (fifo_count != 2'd0);
  assign pop     = m_valid & m_ready;

  // Slots already claimed once this cycle's pop leaves; a new read may only
  // be issued if its returning word is guaranteed a free FIFO entry.
  assign occ_after  = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue      = (state_q == ST_READ) && (rem_q != '0) && (occ_after < 3'(BUF_DEPTH));
  assign last_issue = issue && (rem_q == (ADDR_WIDTH+1)'(1));

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    rem_d           = rem_q;
    inflight_d      = issue;
    inflight_last_d = last_issue;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          rem_d   = cmd_len;
          state_d = (cmd_len == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if (issue) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          rem_d  = rem_q - (ADDR_WIDTH+1)'(1);
          if (last_issue) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Leave as the final word is popped so done follows the last beat directly.
        if (!inflight_q && (fifo_count == {1'b0, pop})) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  sdp_rd_skid_fifo #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data ({inflight_last_q, ram_doutb}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .count     (fifo_count)
  );

  assign ram_renb   = issue;
  assign ram_raddrb = addr_q;
  assign m_data     = fifo_head[DATA_WIDTH-1:0];
  assign m_last     = fifo_head[DATA_WIDTH] & m_valid;
  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);

endmodule
